// File: rtl/tmds_encoder_4ch.sv
// Four-lane DVI TMDS encoder: three 8b/10b data lanes plus a constant clock lane.
// Stage 1 minimises transitions, stage 2 DC-balances against a per-lane running disparity.
module tmds_encoder_4ch (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] tmds_0,
  output logic [9:0] tmds_1,
  output logic [9:0] tmds_2,
  output logic [9:0] tmds_3
);

  localparam logic [9:0] CTRL_00   = 10'b1101010100;
  localparam logic [9:0] CTRL_01   = 10'b0010101011;
  localparam logic [9:0] CTRL_10   = 10'b0101010100;
  localparam logic [9:0] CTRL_11   = 10'b1010101011;
  localparam logic [9:0] CLK_SYMBOL = 10'b1111100000;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(d[i]);
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [3:0] n1;
    logic       xnor_mode;
    logic [8:0] q;
    n1        = ones8(d);
    xnor_mode = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q         = '0;
    q[0]      = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xnor_mode;
    return q;
  endfunction

  // Returns {symbol[9:0], next_cnt[4:0]}; diff is (ones - zeros) of qm[7:0].
  function automatic logic [14:0] balance(input logic [8:0] qm, input logic signed [4:0] cnt,
                                          input logic en, input logic [1:0] ctl);
    logic [3:0]        n1;
    logic signed [4:0] diff;
    logic signed [4:0] two_q8;
    logic signed [4:0] cnt_n;
    logic [9:0]        sym;
    n1     = ones8(qm[7:0]);
    diff   = $signed({n1, 1'b0} - 5'd8);
    two_q8 = $signed({3'b000, qm[8], 1'b0});
    sym    = CTRL_00;
    cnt_n  = '0;
    if (!en) begin
      case (ctl)
        2'b00:   sym = CTRL_00;
        2'b01:   sym = CTRL_01;
        2'b10:   sym = CTRL_10;
        default: sym = CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
      if (qm[8]) begin
        sym   = {2'b01, qm[7:0]};
        cnt_n = cnt + diff;
      end else begin
        sym   = {2'b10, ~qm[7:0]};
        cnt_n = cnt - diff;
      end
    end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + two_q8 - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + diff - (5'sd2 - two_q8);
    end
    return {sym, cnt_n};
  endfunction

  logic [7:0]        din   [3];
  logic [8:0]        qm_q  [3];
  logic signed [4:0] cnt_q [3];
  logic [9:0]        sym_q [3];
  logic [14:0]       bal   [3];
  logic              de_q;
  logic [1:0]        ctl_q;

  assign din[0] = blue;
  assign din[1] = green;
  assign din[2] = red;

  // Only lane 0 carries sync; the other lanes always send control code 00.
  always_comb begin
    bal = '{default: '0};
    for (int l = 0; l < 3; l++)
      bal[l] = balance(qm_q[l], cnt_q[l], de_q, (l == 0) ? ctl_q : 2'b00);
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      ctl_q <= 2'b00;
      for (int l = 0; l < 3; l++) begin
        qm_q[l]  <= '0;
        cnt_q[l] <= '0;
        sym_q[l] <= CTRL_00;
      end
    end else begin
      de_q  <= de;
      ctl_q <= {vsync, hsync};
      for (int l = 0; l < 3; l++) begin
        qm_q[l]  <= min_trans(din[l]);
        cnt_q[l] <= $signed(bal[l][4:0]);
        sym_q[l] <= bal[l][14:5];
      end
    end
  end

  assign tmds_0 = sym_q[0];
  assign tmds_1 = sym_q[1];
  assign tmds_2 = sym_q[2];
  assign tmds_3 = CLK_SYMBOL;

endmodule
